// File: rtl/kme_ob_sink_pkg.sv
// Shared types and helpers for the KME outbound frame sink: the per-frame
// record layout, error bit positions, LFSR constants and strobe helpers.
package kme_ob_sink_pkg;

  // Record fields are sized for the widest stream the sink is built for;
  // the top narrows them to its own DATA_W/TID_W/USER_W.
  localparam int REC_TID_W  = 1;
  localparam int REC_USER_W = 8;
  localparam int REC_DATA_W = 64;
  localparam int STRB_MAX_W = 64;

  localparam int ERR_STRB = 0;
  localparam int ERR_TID  = 1;
  localparam int ERR_OVF  = 2;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef struct packed {
    logic [REC_TID_W-1:0]  tid;
    logic [15:0]           beats;
    logic [18:0]           bytes;
    logic [REC_USER_W-1:0] tuser;
    logic [REC_DATA_W-1:0] sig;
    logic [2:0]            err;
  } rec_t;

  function automatic logic [6:0] popcount(input logic [STRB_MAX_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < STRB_MAX_W; i++) n = n + {6'd0, v[i]};
    return n;
  endfunction

  // True only for a non-empty run of ones starting at bit 0 (0...01...1).
  function automatic logic strb_contig(input logic [STRB_MAX_W-1:0] v);
    logic [STRB_MAX_W-1:0] one;
    one = {{(STRB_MAX_W-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v + one)) == '0);
  endfunction

endpackage

// File: rtl/kme_sync_fifo.sv
// Single-clock FIFO holding items of type T; head is read straight from the
// storage registers so it stays stable until popped.
module kme_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kme_ob_frame_sink.sv
// Outbound AXI-stream consumer for the KME run environment: LFSR-driven
// backpressure, per-frame statistics and a record FIFO for the checker.
module kme_ob_frame_sink
  import kme_ob_sink_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int STRB_W    = DATA_W / 8,
  parameter int TID_W     = 1,
  parameter int USER_W    = 8,
  parameter int REC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ob_tvalid,
  output logic              ob_tready,
  input  logic [TID_W-1:0]  ob_tid,
  input  logic [DATA_W-1:0] ob_tdata,
  input  logic [STRB_W-1:0] ob_tstrb,
  input  logic [USER_W-1:0] ob_tuser,
  input  logic              ob_tlast,
  input  logic              cfg_bp_en,
  input  logic [15:0]       cfg_bp_seed,
  input  logic [3:0]        cfg_bp_thresh,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [TID_W-1:0]  rec_tid,
  output logic [15:0]       rec_beats,
  output logic [18:0]       rec_bytes,
  output logic [USER_W-1:0] rec_tuser,
  output logic [DATA_W-1:0] rec_sig,
  output logic [2:0]        rec_err,
  output logic [31:0]       frames_total
);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Returns {overflow_attempted, saturated_count}.
  function automatic logic [16:0] beats_sat_inc(input logic [15:0] b);
    if (b == 16'hFFFF) return {1'b1, 16'hFFFF};
    return {1'b0, b + 16'd1};
  endfunction

  function automatic logic [DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  logic [15:0]       lfsr;
  logic              stall;
  logic              beat;
  logic              fifo_full;
  logic              fifo_empty;
  rec_t              push_rec;
  rec_t              rec_head;

  logic              in_frame_p0;
  logic [15:0]       acc_beats_p0;
  logic [18:0]       acc_bytes_p0;
  logic [DATA_W-1:0] acc_sig_p0;
  logic [2:0]        acc_err_p0;
  logic [TID_W-1:0]  acc_tid_p0;
  logic [USER_W-1:0] acc_tuser_p0;

  logic [15:0]       base_beats;
  logic [18:0]       base_bytes;
  logic [DATA_W-1:0] base_sig;
  logic [2:0]        base_err;
  logic [TID_W-1:0]  cap_tid;
  logic [USER_W-1:0] cap_tuser;
  logic [15:0]       nxt_beats;
  logic              ovf;
  logic [18:0]       nxt_bytes;
  logic [DATA_W-1:0] nxt_sig;
  logic [2:0]        nxt_err;
  logic              strb_bad;

  assign stall     = cfg_bp_en && (lfsr[3:0] < cfg_bp_thresh);
  assign ob_tready = rst_n && !fifo_full && !stall;
  assign beat      = ob_tvalid && ob_tready;

  // Stage 0: fold the current beat into the running frame totals; a first
  // beat starts from zero and captures its own tid/tuser.
  always_comb begin
    base_beats = in_frame_p0 ? acc_beats_p0 : '0;
    base_bytes = in_frame_p0 ? acc_bytes_p0 : '0;
    base_sig   = in_frame_p0 ? acc_sig_p0   : '0;
    base_err   = in_frame_p0 ? acc_err_p0   : '0;
    cap_tid    = in_frame_p0 ? acc_tid_p0   : ob_tid;
    cap_tuser  = in_frame_p0 ? acc_tuser_p0 : ob_tuser;

    {ovf, nxt_beats} = beats_sat_inc(base_beats);
    nxt_bytes = base_bytes + 19'(popcount(STRB_MAX_W'(ob_tstrb)));
    nxt_sig   = base_sig ^ (ob_tdata & byte_mask(ob_tstrb));
    strb_bad  = ob_tlast ? !strb_contig(STRB_MAX_W'(ob_tstrb))
                         : (ob_tstrb != '1);

    nxt_err           = base_err;
    nxt_err[ERR_STRB] = base_err[ERR_STRB] | strb_bad;
    nxt_err[ERR_TID]  = base_err[ERR_TID] | (in_frame_p0 && (ob_tid != acc_tid_p0));
    nxt_err[ERR_OVF]  = base_err[ERR_OVF] | ovf;

    push_rec       = '0;
    push_rec.tid   = REC_TID_W'(cap_tid);
    push_rec.beats = nxt_beats;
    push_rec.bytes = nxt_bytes;
    push_rec.tuser = REC_USER_W'(cap_tuser);
    push_rec.sig   = REC_DATA_W'(nxt_sig);
    push_rec.err   = nxt_err;
  end

  // Stage 0 -> 1: accumulator registers, or a record push on tlast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr         <= (cfg_bp_seed == 16'h0000) ? LFSR_DEFAULT : cfg_bp_seed;
      in_frame_p0  <= 1'b0;
      acc_beats_p0 <= '0;
      acc_bytes_p0 <= '0;
      acc_sig_p0   <= '0;
      acc_err_p0   <= '0;
      acc_tid_p0   <= '0;
      acc_tuser_p0 <= '0;
      frames_total <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (beat) begin
        if (ob_tlast) begin
          in_frame_p0  <= 1'b0;
          acc_beats_p0 <= '0;
          acc_bytes_p0 <= '0;
          acc_sig_p0   <= '0;
          acc_err_p0   <= '0;
          acc_tid_p0   <= '0;
          acc_tuser_p0 <= '0;
          frames_total <= frames_total + 32'd1;
        end else begin
          in_frame_p0  <= 1'b1;
          acc_beats_p0 <= nxt_beats;
          acc_bytes_p0 <= nxt_bytes;
          acc_sig_p0   <= nxt_sig;
          acc_err_p0   <= nxt_err;
          acc_tid_p0   <= cap_tid;
          acc_tuser_p0 <= cap_tuser;
        end
      end
    end
  end

  // Stage 1: completed frame records wait here for the checker.
  kme_sync_fifo #(
    .T     (rec_t),
    .DEPTH (REC_DEPTH)
  ) u_rec_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (beat && ob_tlast),
    .push_data (push_rec),
    .pop       (rec_ready),
    .head      (rec_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign rec_tid   = rec_head.tid[TID_W-1:0];
  assign rec_beats = rec_head.beats;
  assign rec_bytes = rec_head.bytes;
  assign rec_tuser = rec_head.tuser[USER_W-1:0];
  assign rec_sig   = rec_head.sig[DATA_W-1:0];
  assign rec_err   = rec_head.err;

endmodule

// File: tb/tb_kme_ob_frame_sink.sv
// Scoreboard bench for kme_ob_frame_sink: directed frames push expected
// records; a negedge monitor pops and compares each handshaken record.
module tb_kme_ob_frame_sink;
  import kme_ob_sink_pkg::*;

  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int TID_W  = 1;
  localparam int USER_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ob_tvalid = 1'b0;
  logic              ob_tready;
  logic [TID_W-1:0]  ob_tid = '0;
  logic [DATA_W-1:0] ob_tdata = '0;
  logic [STRB_W-1:0] ob_tstrb = '0;
  logic [USER_W-1:0] ob_tuser = '0;
  logic              ob_tlast = 1'b0;
  logic              cfg_bp_en = 1'b0;
  logic [15:0]       cfg_bp_seed = '0;
  logic [3:0]        cfg_bp_thresh = '0;
  logic              rec_valid;
  logic              rec_ready = 1'b1;
  logic [TID_W-1:0]  rec_tid;
  logic [15:0]       rec_beats;
  logic [18:0]       rec_bytes;
  logic [USER_W-1:0] rec_tuser;
  logic [DATA_W-1:0] rec_sig;
  logic [2:0]        rec_err;
  logic [31:0]       frames_total;

  rec_t exp_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   n_rec  = 0;
  int   stall_cycles = 0;

  always #5 clk = ~clk;

  kme_ob_frame_sink #(
    .DATA_W(DATA_W), .STRB_W(STRB_W), .TID_W(TID_W), .USER_W(USER_W), .REC_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tid(ob_tid),
    .ob_tdata(ob_tdata), .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tlast(ob_tlast),
    .cfg_bp_en(cfg_bp_en), .cfg_bp_seed(cfg_bp_seed), .cfg_bp_thresh(cfg_bp_thresh),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_tid(rec_tid),
    .rec_beats(rec_beats), .rec_bytes(rec_bytes), .rec_tuser(rec_tuser),
    .rec_sig(rec_sig), .rec_err(rec_err), .frames_total(frames_total)
  );

  function automatic rec_t mk(input logic [TID_W-1:0] tid, input logic [15:0] beats,
                              input logic [18:0] bytes, input logic [7:0] tuser,
                              input logic [63:0] sig, input logic [2:0] err);
    rec_t r;
    r = '0;
    r.tid = tid; r.beats = beats; r.bytes = bytes;
    r.tuser = tuser; r.sig = sig; r.err = err;
    return r;
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Monitor: a record is consumed at the next posedge when valid & ready.
  always @(negedge clk) begin
    rec_t act;
    rec_t exp;
    if (rst_n && rec_valid && rec_ready) begin
      act = mk(rec_tid, rec_beats, rec_bytes, rec_tuser, rec_sig, rec_err);
      n_asrt++;
      n_rec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rec_unexpected #%0d got beats=%h bytes=%h tuser=%h sig=%h err=%b, none expected",
                 n_rec, act.beats, act.bytes, act.tuser, act.sig, act.err);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL rec#%0d got tid=%h beats=%h bytes=%h tuser=%h sig=%h err=%b want tid=%h beats=%h bytes=%h tuser=%h sig=%h err=%b",
                   n_rec, act.tid, act.beats, act.bytes, act.tuser, act.sig, act.err,
                   exp.tid, exp.beats, exp.bytes, exp.tuser, exp.sig, exp.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [TID_W-1:0] tid, input logic [63:0] data,
                           input logic [7:0] strb, input logic [7:0] user, input logic last);
    int waits;
    ob_tvalid = 1'b1; ob_tid = tid; ob_tdata = data;
    ob_tstrb = strb; ob_tuser = user; ob_tlast = last;
    waits = 0;
    @(negedge clk);
    while (!ob_tready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!ob_tready) begin
      n_asrt++;
      n_fail++;
      $display("FAIL beat_timeout got ready=0 after %0d cycles want ready=1", waits);
    end
    stall_cycles += waits;
    @(posedge clk);
    #1;
    ob_tvalid = 1'b0;
    ob_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_asrt++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got pending=%0d want=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] seed);
    cfg_bp_seed = seed;
    ob_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(ob_tready), 64'd0);
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_frames_total", 64'(frames_total), 64'd0);
    chk("rst_rec_fields", 64'({rec_beats, rec_bytes, rec_tuser, rec_err, rec_tid}), 64'd0);
    chk("rst_rec_sig", rec_sig, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic frames_4x4();
    exp_q.push_back(mk(1'b0, 16'd4, 19'd32, 8'h11, 64'h00F, 3'b000));
    for (int j = 0; j < 4; j++) send_beat(1'b0, 64'h1 << j, 8'hFF, 8'h11, j == 3);
    exp_q.push_back(mk(1'b0, 16'd4, 19'd32, 8'h22, 64'h0F0, 3'b000));
    for (int j = 0; j < 4; j++) send_beat(1'b0, 64'h10 << j, 8'hFF, 8'h22, j == 3);
    exp_q.push_back(mk(1'b0, 16'd4, 19'd32, 8'h33, 64'hF00, 3'b000));
    for (int j = 0; j < 4; j++) send_beat(1'b0, 64'h100 << j, 8'hFF, 8'h33, j == 3);
  endtask

  initial begin
    int hold_bad;
    int waits;
    int stalls;
    int bad;
    logic [15:0] m;

    // Unthrottled baseline
    cfg_bp_en = 1'b0; cfg_bp_thresh = 4'd0; rec_ready = 1'b1;
    do_reset(16'h0000);
    stall_cycles = 0;
    frames_4x4();
    chk("t1_no_stall", 64'(stall_cycles), 64'd0);
    wait_drain();
    chk("t1_frames_total", 64'(frames_total), 64'd3);

    // Strobe rules
    exp_q.push_back(mk(1'b0, 16'd1, 19'd3, 8'h44, 64'h0000_0000_00CC_DDDD, 3'b000));
    send_beat(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h07, 8'h44, 1'b1);
    exp_q.push_back(mk(1'b0, 16'd1, 19'd2, 8'h55, 64'h0000_0000_00CC_00DD, 3'b001));
    send_beat(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h05, 8'h55, 1'b1);
    exp_q.push_back(mk(1'b0, 16'd2, 19'd15, 8'h66, 64'h00FF_FFFF_FFFF_FFFF, 3'b001));
    send_beat(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h7F, 8'h66, 1'b0);
    send_beat(1'b0, 64'h0, 8'hFF, 8'h66, 1'b1);
    wait_drain();

    // FIFO full backpressure and ordered drain
    rec_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(1'b0, 16'd1, 19'd8, 8'(8'h71 + k), 64'(64'hA0 + k), 3'b000));
      send_beat(1'b0, 64'(64'hA0 + k), 8'hFF, 8'(8'h71 + k), 1'b1);
    end
    @(negedge clk);
    chk("t3_full_tready", 64'(ob_tready), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 16'd1, 19'd8, 8'h75, 64'hA4, 3'b000));
    ob_tvalid = 1'b1; ob_tid = 1'b0; ob_tdata = 64'hA4;
    ob_tstrb = 8'hFF; ob_tuser = 8'h75; ob_tlast = 1'b1;
    hold_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ob_tready) hold_bad++;
    end
    chk("t3_fifth_held", 64'(hold_bad), 64'd0);
    @(posedge clk);
    #1;
    rec_ready = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!ob_tready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("t3_fifth_accept", 64'(ob_tready), 64'd1);
    @(posedge clk);
    #1;
    ob_tvalid = 1'b0; ob_tlast = 1'b0;
    wait_drain();
    chk("t3_frames_total", 64'(frames_total), 64'd11);

    // Random backpressure
    cfg_bp_en = 1'b1; cfg_bp_thresh = 4'd8;
    do_reset(16'h1234);
    stalls = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (!ob_tready) stalls++;
    end
    n_asrt++;
    if (stalls < 1843 || stalls > 2253) begin
      n_fail++;
      $display("FAIL bp_ratio got stalls=%0d/4096 want 1843..2253", stalls);
    end
    @(posedge clk);
    #1;
    frames_4x4();
    wait_drain();
    chk("t4_frames_total", 64'(frames_total), 64'd3);

    // Seed 0 falls back to 0xACE1
    do_reset(16'h0000);
    m = 16'hACE1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ob_tready !== !(m[3:0] < 4'd8)) bad++;
      m = model_step(m);
    end
    chk("seed0_pattern", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    cfg_bp_en = 1'b0;

    // tid change and beat-count saturation
    exp_q.push_back(mk(1'b0, 16'd3, 19'd24, 8'h99, 64'h7, 3'b010));
    send_beat(1'b0, 64'h1, 8'hFF, 8'h99, 1'b0);
    send_beat(1'b0, 64'h2, 8'hFF, 8'h99, 1'b0);
    send_beat(1'b1, 64'h4, 8'hFF, 8'h99, 1'b1);
    exp_q.push_back(mk(1'b0, 16'hFFFF, 19'd8, 8'h5A, 64'h10000, 3'b100));
    for (int i = 0; i < 65537; i++) send_beat(1'b0, 64'(i), 8'hFF, 8'h5A, i == 65536);
    wait_drain();

    // Reset mid-frame discards the partial frame
    send_beat(1'b0, 64'h5, 8'hFF, 8'hCC, 1'b0);
    send_beat(1'b0, 64'h5, 8'hFF, 8'hCC, 1'b0);
    do_reset(16'h0000);
    exp_q.push_back(mk(1'b0, 16'd2, 19'd16, 8'hBB, 64'h30, 3'b000));
    send_beat(1'b0, 64'h10, 8'hFF, 8'hBB, 1'b0);
    send_beat(1'b0, 64'h20, 8'hFF, 8'hBB, 1'b1);
    wait_drain();
    chk("t6_frames_total", 64'(frames_total), 64'd1);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
